// File: rtl/adder_arbiter.sv
// adder_arbiter: one shared 32-bit adder serving NREQ requesters via round-robin grant
// Registered sum is tagged with the requester id and held under backpressure.
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_y,
  output logic                 rsp_ovf
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [0:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] gid;
  logic           found;
  logic           grant;
  logic [31:0]    a, b, y;
  always_comb begin
    idx   = '0;
    gid   = '0;
    found = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      idx = IDW'((int'(rr_ptr) + j) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gid   = idx;
      end
    end
  end
  assign grant     = reset_n & found & ((state == EMPTY) | rsp_ready);
  assign req_ready = grant ? NREQ'(1) << gid : '0;
  assign rsp_valid = (state == FULL);
  assign a         = req_a[32*gid +: 32];
  assign b         = req_b[32*gid +: 32];
  assign y         = a + b;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= EMPTY;
      rr_ptr <= '0;
      rsp_id <= '0;
      rsp_y  <= '0;
      rsp_ovf <= 1'b0;
    end else if (grant) begin
      state   <= FULL;
      rr_ptr  <= (gid == IDW'(NREQ-1)) ? '0 : gid + 1'b1;
      rsp_id  <= gid;
      rsp_y   <= y;
      rsp_ovf <= (a[31] == b[31]) && (y[31] != a[31]);
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end
endmodule
